// File: rtl/uart_rx_data_sampler.sv
// Oversampling majority-vote data sampler for the UART receiver (3 or 5 samples around mid-bit).
// Optional macro UART_RX_SAMPLER_SYNC_EN adds a 2-flop synchroniser on RX_IN.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sample_enable,
  input  logic [PRESCALE_W-1:0] edge_counter,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  vote5,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int DW = PRESCALE_W + 1;

  function automatic logic [2:0] ones_count(input logic [4:0] v, input logic use5);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) begin
      c = c + {2'b00, v[i] & (use5 | ((i >= 1) && (i <= 3)))};
    end
    return c;
  endfunction

  logic                  rx_s;
  logic [4:0]            buf_q, buf_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  noise_flag_q, noise_flag_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  vote5_q, vote5_d;

  logic                  cfg_bad_s, use5_s, cfg_chg_s, active_s, in_win_s, last_s, do_vote_s;
  logic [PRESCALE_W-1:0] center_s;
  logic [DW-1:0]         diff_s;
  logic [2:0]            slot_s, ones_s;
  logic [4:0]            samples_s;

`ifdef UART_RX_SAMPLER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], RX_IN};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  // diff_s is the offset of edge_counter from the first 5-sample point (C-2); wraps high when before it
  always_comb begin
    cfg_bad_s = Prescale[0] | (Prescale < PRESCALE_W'(4));
    use5_s    = vote5 & (Prescale >= PRESCALE_W'(8));
    center_s  = Prescale >> 1;
    diff_s    = {1'b0, edge_counter} - {1'b0, center_s} + DW'(2);
    slot_s    = diff_s[2:0];
    if (use5_s) begin
      in_win_s = (diff_s <= DW'(4));
      last_s   = (diff_s == DW'(4));
    end else begin
      in_win_s = (diff_s >= DW'(1)) && (diff_s <= DW'(3));
      last_s   = (diff_s == DW'(3));
    end
    cfg_chg_s = (Prescale != prescale_q) | (vote5 != vote5_q);
    active_s  = data_sample_enable & ~cfg_bad_s & ~cfg_chg_s;
    do_vote_s = active_s & in_win_s & last_s;

    for (int i = 0; i < 5; i++) begin
      samples_s[i] = (in_win_s && (slot_s == 3'(i))) ? rx_s : buf_q[i];
    end
    ones_s = ones_count(samples_s, use5_s);

    // Window restarts from all-ones after a vote so that skipped points count as 1
    if (!active_s || do_vote_s) begin
      buf_d = 5'b11111;
    end else if (in_win_s) begin
      buf_d = samples_s;
    end else begin
      buf_d = buf_q;
    end

    if (do_vote_s) begin
      sampled_bit_d = use5_s ? (ones_s >= 3'd3) : (ones_s >= 3'd2);
      noise_flag_d  = (ones_s != 3'd0) && (ones_s != (use5_s ? 3'd5 : 3'd3));
    end else begin
      sampled_bit_d = sampled_bit_q;
      noise_flag_d  = noise_flag_q;
    end
    sample_valid_d = do_vote_s;
    cfg_err_d      = cfg_bad_s;
    prescale_d     = Prescale;
    vote5_d        = vote5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q          <= 5'b11111;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
      prescale_q     <= '0;
      vote5_q        <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      noise_flag_q   <= noise_flag_d;
      cfg_err_q      <= cfg_err_d;
      prescale_q     <= prescale_d;
      vote5_q        <= vote5_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign noise_flag   = noise_flag_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for uart_rx_data_sampler: table of full windows plus hand-written corner sequences.
module tb_uart_rx_data_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_sample_enable = 1'b0;
  logic [5:0] edge_counter = 6'd0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       vote5 = 1'b0;
  logic       sampled_bit, sample_valid, noise_flag, cfg_err;

  int checks = 0;
  int errors = 0;
  logic model_bit = 1'b1;
  logic model_noise = 1'b0;
  logic [1:0] sb_q[$];

  typedef struct {
    int          presc;
    logic        v5;
    logic [63:0] mask;
    logic        exp_bit;
    logic        exp_noise;
  } win_t;

  win_t tbl[8];

  uart_rx_data_sampler #(.PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .data_sample_enable(data_sample_enable),
    .edge_counter(edge_counter), .RX_IN(RX_IN), .Prescale(Prescale), .vote5(vote5),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid), .noise_flag(noise_flag),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic en, input int ec, input logic rx,
                      input logic ev, input logic eb, input logic enz);
    logic [1:0] exp;
    data_sample_enable = en;
    edge_counter = ec[5:0];
    RX_IN = rx;
    if (ev) sb_q.push_back({eb, enz});
    @(posedge clk);
    #1;
    if (rst) begin
      model_bit = 1'b1;
      model_noise = 1'b0;
    end
    checks++;
    if (sample_valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL valid_pulse: sample_valid=1 required 0 (edge %0d)", ec);
      end else begin
        exp = sb_q.pop_front();
        model_bit = exp[1];
        model_noise = exp[0];
      end
    end else if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL valid_pulse: sample_valid=0 required 1 (edge %0d)", ec);
      exp = sb_q.pop_front();
      model_bit = exp[1];
      model_noise = exp[0];
    end
    checks++;
    if (sampled_bit !== model_bit) begin
      errors++;
      $display("FAIL sampled_bit: got %b required %b (edge %0d)", sampled_bit, model_bit, ec);
    end
    checks++;
    if (noise_flag !== model_noise) begin
      errors++;
      $display("FAIL noise_flag: got %b required %b (edge %0d)", noise_flag, model_noise, ec);
    end
  endtask

  task automatic check_cfg(input logic exp);
    checks++;
    if (cfg_err !== exp) begin
      errors++;
      $display("FAIL cfg_err: got %b required %b", cfg_err, exp);
    end
  endtask

  task automatic run_window(input int p, input logic v5, input logic [63:0] mask,
                            input logic eb, input logic enz);
    int n;
    int last;
    Prescale = p[5:0];
    vote5 = v5;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b0);
    n = (v5 && p >= 8) ? 5 : 3;
    last = p / 2 + (n - 1) / 2;
    for (int e = 0; e < p; e++) step(1'b1, e, mask[e], e == last, eb, enz);
  endtask

  initial begin
    tbl[0] = '{8,  1'b0, 64'h0,                1'b0, 1'b0};
    tbl[1] = '{16, 1'b1, 64'h40,               1'b0, 1'b1};
    tbl[2] = '{6,  1'b1, 64'h14,               1'b1, 1'b1};
    tbl[3] = '{32, 1'b0, 64'hFFFF_FFFF,        1'b1, 1'b0};
    tbl[4] = '{16, 1'b0, 64'h100,              1'b0, 1'b1};
    tbl[5] = '{8,  1'b1, 64'h2C,               1'b1, 1'b1};
    tbl[6] = '{4,  1'b1, 64'h0,                1'b0, 1'b0};
    tbl[7] = '{10, 1'b1, ~64'h20,              1'b1, 1'b1};

    // reset state
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_window(tbl[i].presc, tbl[i].v5, tbl[i].mask, tbl[i].exp_bit, tbl[i].exp_noise);

    // enable drops at edge 8: no vote, prior bit held, next window votes
    Prescale = 6'd16; vote5 = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 8; e++) step(1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 8; e < 16; e++) step(1'b0, e, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window(16, 1'b0, 64'h0, 1'b0, 1'b0);

    // edge 8 skipped: its slot stays 1
    for (int e = 0; e < 16; e++)
      if (e != 8) step(1'b1, e, 1'b0, e == 9, 1'b0, 1'b1);

    // vote5 flips at the last point: window discarded
    run_window(16, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int e = 0; e < 9; e++) step(1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0);
    vote5 = 1'b1;
    step(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0);

    // invalid prescale: cfg_err one cycle later, no votes for 3 windows
    Prescale = 6'd7; vote5 = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b1);
    for (int w = 0; w < 3; w++)
      for (int e = 0; e < 7; e++) step(1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b1);
    Prescale = 6'd8;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b0);
    run_window(8, 1'b0, 64'hFF, 1'b1, 1'b0);

    // reset mid-window at edge 8
    run_window(16, 1'b0, 64'h100, 1'b0, 1'b1);
    for (int e = 0; e < 8; e++) step(1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cfg(1'b0);
    rst = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
